store_queue_be: RTL and testbench

- Parametrised successor to the combinational byte-enable store formatter.
- Accepts store requests (sb/sh/sw, wider words when parametrised) from the MEM stage, checks alignment and forms lane-aligned data plus byte enables.
- Buffers stores in a DEPTH-entry FIFO and merges consecutive stores to the same aligned word.
- Drains stores to the data memory/bridge over a valid/ready handshake; sits between the MEM stage and the DM/bridge write port.

---
 rtl/store_queue_be.sv | 127 ++++++++++++
 tb/tb_store_queue_be.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_be.sv
// rtl/store_queue_be.sv - store formatter with alignment check, merging FIFO and valid/ready drain
// Stores are lane-placed on entry; a store to the tail-most entry's word folds into it.
module store_queue_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [1:0]                  in_size,
    input  logic                        in_req,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [DATA_W/8-1:0]         mem_be,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        align_err
);
    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [NB-1:0]     r_be   [DEPTH];
    logic [PTRW-1:0]   r_head;
    logic [PTRW-1:0]   r_tail;
    logic [CNTW-1:0]   r_count;
    logic              r_align_err;

    logic [OFFW-1:0]   w_off;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [NB-1:0]     w_be;
    logic              w_aligned;
    logic              w_full;
    logic              w_valid;
    logic              w_fire;
    logic              w_accept;
    logic              w_misalign;
    logic              w_pop;
    logic              w_merge;
    logic              w_push;
    logic [PTRW-1:0]   w_last;

    assign w_off   = in_addr[OFFW-1:0];
    assign w_waddr = {in_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign w_full  = (r_count == CNTW'(DEPTH));
    assign w_valid = (r_count != '0);
    assign w_last  = r_tail - 1'b1;

    always_comb begin
        w_aligned = 1'b0;
        w_be      = '0;
        w_wdata   = '0;
        case (in_size)
            2'd0: begin
                w_aligned = 1'b1;
                w_be      = NB'(1) << w_off;
                w_wdata   = DATA_W'(in_data[7:0]) << {w_off, 3'b000};
            end
            2'd1: begin
                w_aligned = ~in_addr[0];
                w_be      = NB'(3) << w_off;
                w_wdata   = DATA_W'(in_data[15:0]) << {w_off, 3'b000};
            end
            2'd2: begin
                w_aligned = (w_off == '0);
                w_be      = '1;
                w_wdata   = in_data;
            end
            default: ;
        endcase
    end

    assign w_fire     = in_valid & ~w_full & ~in_req;
    assign w_accept   = w_fire & w_aligned;
    assign w_misalign = w_fire & ~w_aligned;
    assign w_pop      = w_valid & mem_ready;
    // The head may only be merged into when it is not leaving this very edge.
    assign w_merge    = w_accept && (r_addr[w_last] == w_waddr) &&
                        ((r_count >= CNTW'(2)) || ((r_count == CNTW'(1)) && !w_pop));
    assign w_push     = w_accept & ~w_merge;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= w_misalign;
            if (w_merge) begin
                r_be[w_last] <= r_be[w_last] | w_be;
                for (int i = 0; i < NB; i++) begin
                    if (w_be[i]) r_data[w_last][i*8 +: 8] <= w_wdata[i*8 +: 8];
                end
            end
            if (w_push) begin
                r_addr[r_tail] <= w_waddr;
                r_data[r_tail] <= w_wdata;
                r_be[r_tail]   <= w_be;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop) r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready  = ~w_full;
    assign mem_valid = w_valid;
    assign mem_addr  = w_valid ? r_addr[r_head] : '0;
    assign mem_wdata = w_valid ? r_data[r_head] : '0;
    assign mem_be    = w_valid ? r_be[r_head]   : '0;
    assign count     = r_count;
    assign align_err = r_align_err;
endmodule

// File: tb/tb_store_queue_be.sv
// tb/tb_store_queue_be.sv - self-checking bench for store_queue_be with a queue-based reference model
module tb_store_queue_be;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_req, mem_valid, mem_ready, align_err;
    logic [31:0] in_addr, in_data, mem_addr, mem_wdata;
    logic [1:0]  in_size;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    logic        w_in_valid, w_in_ready, w_mem_valid, w_align_err;
    logic [31:0] w_in_addr, w_mem_addr;
    logic [63:0] w_in_data, w_mem_wdata;
    logic [7:0]  w_mem_be;
    logic [2:0]  w_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;
    entry_t q[$];
    bit     m_err;

    always #5 clk = ~clk;

    store_queue_be #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_size(in_size), .in_req(in_req),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .count(count), .align_err(align_err)
    );

    store_queue_be #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_addr(w_in_addr), .in_data(w_in_data), .in_size(2'd1), .in_req(1'b0),
        .mem_valid(w_mem_valid), .mem_ready(1'b0), .mem_addr(w_mem_addr),
        .mem_wdata(w_mem_wdata), .mem_be(w_mem_be), .count(w_count), .align_err(w_align_err)
    );

    // Reference: advance the queue model from the inputs present before the edge, then clock.
    task automatic tick();
        bit          pop, fire, al, acc, merge;
        int          off;
        logic [31:0] nd;
        logic [3:0]  nb;
        entry_t      e;
        if (!reset_n) begin
            q.delete();
            m_err = 0;
        end else begin
            pop  = (q.size() != 0) && mem_ready;
            fire = in_valid && (q.size() < DEPTH) && !in_req;
            case (in_size)
                2'd0:    al = 1;
                2'd1:    al = (in_addr % 2) == 0;
                2'd2:    al = (in_addr % 4) == 0;
                default: al = 0;
            endcase
            m_err = fire && !al;
            acc   = fire && al;
            merge = 0;
            if (acc) begin
                off = int'(in_addr % 4);
                if (in_size == 2'd0) begin
                    nd = (in_data & 32'hFF) << (8 * off);
                    nb = 4'b0001 << off;
                end else if (in_size == 2'd1) begin
                    nd = (in_data & 32'hFFFF) << (8 * off);
                    nb = 4'b0011 << off;
                end else begin
                    nd = in_data;
                    nb = 4'b1111;
                end
                e.addr = in_addr - (in_addr % 4);
                e.data = nd;
                e.be   = nb;
                if (q.size() > 0 && q[q.size()-1].addr == e.addr && (q.size() >= 2 || !pop)) begin
                    merge = 1;
                    e = q[q.size()-1];
                    for (int i = 0; i < 4; i++)
                        if (nb[i]) e.data[i*8 +: 8] = nd[i*8 +: 8];
                    e.be = e.be | nb;
                    q[q.size()-1] = e;
                end
            end
            if (pop) void'(q.pop_front());
            if (acc && !merge) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0;
        in_req   = 0;
        in_size  = 2'd0;
        in_addr  = '0;
        in_data  = '0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        in_valid = 1;
        in_size  = sz;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic drain();
        mem_ready = 1;
        idle();
        for (int c = 0; c < 10 && count != 0; c++) tick();
        n_cmp++;
        if (count !== 3'd0) begin
            $display("FAIL drain_timeout count=%0d want 0", count);
            n_err++;
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        mem_ready = 0;
        idle();
        w_in_valid = 0; w_in_addr = '0; w_in_data = '0;
        tick(); tick();
        reset_n = 1;
        n_cmp++;
        if ({count, mem_valid, align_err, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_ctrl got cnt=%0d v=%b e=%b r=%b want 0 0 0 1", count, mem_valid, align_err, in_ready);
            n_err++;
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_be} !== 68'd0) begin
            $display("FAIL reset_data got a=%h d=%h be=%b want 0", mem_addr, mem_wdata, mem_be);
            n_err++;
        end
    endtask

    task automatic test_sb();
        mem_ready = 1;
        store(2'd0, 32'h1003, 32'h12);
        tick();
        idle();
        n_cmp++;
        if ({mem_valid, mem_addr, mem_be, mem_wdata, count} !== {1'b1, 32'h1000, 4'b1000, 32'h12000000, 3'd1}) begin
            $display("FAIL sb_place got v=%b a=%h be=%b d=%h c=%0d want 1 1000 1000 12000000 1",
                     mem_valid, mem_addr, mem_be, mem_wdata, count);
            n_err++;
        end
        tick();
        n_cmp++;
        if (count !== 3'd0) begin
            $display("FAIL sb_pop count=%0d want 0", count);
            n_err++;
        end
    endtask

    task automatic test_merge();
        mem_ready = 0;
        store(2'd1, 32'h2002, 32'hBEEF);
        tick();
        store(2'd0, 32'h2000, 32'h55);
        tick();
        idle();
        n_cmp++;
        if ({count, mem_be, mem_wdata, mem_addr} !== {3'd1, 4'b1101, 32'hBEEF0055, 32'h2000}) begin
            $display("FAIL merge got c=%0d be=%b d=%h a=%h want 1 1101 beef0055 2000", count, mem_be, mem_wdata, mem_addr);
            n_err++;
        end
        drain();
    endtask

    task automatic test_full();
        logic [31:0] seen[$];
        bit          sent, done;
        mem_ready = 0;
        for (int k = 0; k < 4; k++) begin
            store(2'd2, 32'(k * 4), 32'hA0 + 32'(k));
            tick();
        end
        idle();
        n_cmp++;
        if ({in_ready, count} !== {1'b0, 3'd4}) begin
            $display("FAIL full_ready got r=%b c=%0d want 0 4", in_ready, count);
            n_err++;
        end
        store(2'd2, 32'h10, 32'hA4);
        tick();
        n_cmp++;
        if (count !== 3'd4) begin
            $display("FAIL full_hold count=%0d want 4", count);
            n_err++;
        end
        mem_ready = 1;
        sent = 0;
        done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (mem_valid) seen.push_back(mem_addr);
            if (in_valid && in_ready) begin
                tick();
                idle();
                sent = 1;
            end else begin
                tick();
            end
            done = sent && (count == 0);
        end
        n_cmp++;
        if (!done || seen.size() != 5) begin
            $display("FAIL full_order_len got %0d pops done=%b want 5", seen.size(), done);
            n_err++;
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (seen[k] !== 32'(k * 4)) begin
                    $display("FAIL full_order[%0d] got %h want %h", k, seen[k], k * 4);
                    n_err++;
                end
            end
        end
    endtask

    task automatic test_align();
        logic [1:0]  sz[3] = '{2'd1, 2'd2, 2'd3};
        logic [31:0] ad[3] = '{32'h3001, 32'h3002, 32'h3000};
        mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            store(sz[k], ad[k], 32'hFFFF_FFFF);
            tick();
            idle();
            n_cmp++;
            if ({align_err, count} !== {1'b1, 3'd0}) begin
                $display("FAIL align_pulse[%0d] got e=%b c=%0d want 1 0", k, align_err, count);
                n_err++;
            end
            tick();
            n_cmp++;
            if (align_err !== 1'b0) begin
                $display("FAIL align_once[%0d] got %b want 0", k, align_err);
                n_err++;
            end
            store(sz[k], ad[k], 32'hFFFF_FFFF);
            in_req = 1;
            tick();
            idle();
            n_cmp++;
            if ({align_err, count} !== {1'b0, 3'd0}) begin
                $display("FAIL align_req[%0d] got e=%b c=%0d want 0 0", k, align_err, count);
                n_err++;
            end
        end
    endtask

    task automatic test_pop_merge();
        mem_ready = 0;
        store(2'd0, 32'h4000, 32'hAA);
        tick();
        mem_ready = 1;
        store(2'd0, 32'h4001, 32'h77);
        tick();
        idle();
        mem_ready = 0;
        n_cmp++;
        if ({count, mem_be, mem_wdata, mem_addr} !== {3'd1, 4'b0010, 32'h00007700, 32'h4000}) begin
            $display("FAIL pop_nomerge got c=%0d be=%b d=%h a=%h want 1 0010 00007700 4000", count, mem_be, mem_wdata, mem_addr);
            n_err++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            store(2'd2, 32'h5000 + 32'(k * 4), 32'h1);
            tick();
        end
        idle();
        reset_n = 0;
        mem_ready = 1;
        tick();
        mem_ready = 0;
        n_cmp++;
        if ({count, mem_valid} !== {3'd0, 1'b0}) begin
            $display("FAIL reset_mid got c=%0d v=%b want 0 0", count, mem_valid);
            n_err++;
        end
        reset_n = 1;
        tick();
    endtask

    task automatic test_wide();
        w_in_valid = 1;
        w_in_addr  = 32'h06;
        w_in_data  = 64'hA5A5;
        tick();
        w_in_valid = 0;
        n_cmp++;
        if ({w_mem_be, w_mem_addr, w_mem_wdata, w_count} !== {8'b1100_0000, 32'h0, 64'hA5A5_0000_0000_0000, 3'd1}) begin
            $display("FAIL wide64 got be=%b a=%h d=%h c=%0d want 11000000 0 a5a5000000000000 1",
                     w_mem_be, w_mem_addr, w_mem_wdata, w_count);
            n_err++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset_n   = ($urandom_range(0, 79) != 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_req    = ($urandom_range(0, 7) == 0);
            in_size   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            in_addr   = 32'h6000 + 32'($urandom_range(0, 15));
            in_data   = $urandom;
            tick();
            n_cmp++;
            if (count !== 3'(q.size()) || mem_valid !== (q.size() != 0) ||
                in_ready !== (q.size() < DEPTH) || align_err !== m_err) begin
                $display("FAIL rand_ctrl[%0d] got c=%0d v=%b r=%b e=%b want c=%0d e=%b",
                         c, count, mem_valid, in_ready, align_err, q.size(), m_err);
                n_err++;
            end
            n_cmp++;
            if (q.size() == 0) begin
                if ({mem_addr, mem_wdata, mem_be} !== 68'd0) begin
                    $display("FAIL rand_empty[%0d] got a=%h d=%h be=%b want 0", c, mem_addr, mem_wdata, mem_be);
                    n_err++;
                end
            end else if (mem_addr !== q[0].addr || mem_wdata !== q[0].data || mem_be !== q[0].be) begin
                $display("FAIL rand_head[%0d] got a=%h d=%h be=%b want a=%h d=%h be=%b",
                         c, mem_addr, mem_wdata, mem_be, q[0].addr, q[0].data, q[0].be);
                n_err++;
            end
        end
        reset_n = 1;
        drain();
    endtask

    initial begin
        test_reset();
        test_sb();
        test_merge();
        test_full();
        test_align();
        test_pop_merge();
        test_reset_mid();
        test_wide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
